// File: rtl/hu_audiodec_dma_seq.sv
// hu_audiodec_dma_seq: chunked DMA sequencer for the HU audio decoder tile.
// Latches the transfer configuration on conf_done, then for each chunk issues a
// DMA read request, streams the read words to the datapath, issues a DMA write
// request and streams the datapath results back out. Pulses acc_done at the end.
// Ports:
//   clk, rst (synchronous, active-low), conf_done, conf_info_* : control/config
//   dma_read_ctrl_*  / dma_read_chnl_*  : DMA read request and read data
//   dma_write_ctrl_* / dma_write_chnl_* : DMA write request and write data
//   cmp_in_* / cmp_out_*                : words to / results from the datapath
//   acc_done : one-cycle completion pulse; debug : status word
// Optional feature macro: HU_AUDIODEC_SEQ_DEBUG_EN (drives debug with state,
// completed-chunk count and beat; without it debug is tied to zero).
module hu_audiodec_dma_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        conf_done,
  input  logic [31:0] conf_info_src_offset,
  input  logic [31:0] conf_info_dst_offset,
  input  logic [31:0] conf_info_num_words,
  input  logic [15:0] conf_info_chunk_words,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [31:0] dma_read_chnl_data,
  output logic        dma_write_ctrl_valid,
  input  logic        dma_write_ctrl_ready,
  output logic [31:0] dma_write_ctrl_data_index,
  output logic [31:0] dma_write_ctrl_data_length,
  output logic [2:0]  dma_write_ctrl_data_size,
  output logic        dma_write_chnl_valid,
  input  logic        dma_write_chnl_ready,
  output logic [31:0] dma_write_chnl_data,
  output logic        cmp_in_valid,
  input  logic        cmp_in_ready,
  output logic [31:0] cmp_in_data,
  input  logic        cmp_out_valid,
  output logic        cmp_out_ready,
  input  logic [31:0] cmp_out_data,
  output logic        acc_done,
  output logic [31:0] debug
);

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam logic [2:0]  DMA_SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] src_q, dst_q, remaining_q, offset_q;
  logic [LW-1:0] chunk_q, beat_q, cur_len;
  logic          rd_fire, wr_fire, last_beat;

  // Current chunk length: the configured chunk, or whatever is left if smaller.
  assign cur_len   = (remaining_q < DW'(chunk_q)) ? remaining_q[LW-1:0] : chunk_q;
  assign rd_fire   = (state_q == S_RD_DATA) && dma_read_chnl_valid && cmp_in_ready;
  assign wr_fire   = (state_q == S_WR_DATA) && cmp_out_valid && dma_write_chnl_ready;
  assign last_beat = (beat_q == LW'(1));

  // Data words pass straight through; only the handshakes are gated by state.
  assign cmp_in_data              = dma_read_chnl_data;
  assign dma_write_chnl_data      = cmp_out_data;
  assign dma_read_ctrl_data_size  = DMA_SIZE_WORD;
  assign dma_write_ctrl_data_size = DMA_SIZE_WORD;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (conf_done)
                   state_d = (conf_info_num_words == '0) ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (dma_read_ctrl_ready) state_d = S_RD_DATA;
      S_RD_DATA: if (rd_fire && last_beat) state_d = S_WR_REQ;
      S_WR_REQ:  if (dma_write_ctrl_ready) state_d = S_WR_DATA;
      S_WR_DATA: if (wr_fire && last_beat)
                   state_d = (remaining_q == DW'(cur_len)) ? S_DONE : S_RD_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: every handshake is low outside its own state.
  always_comb begin
    dma_read_ctrl_valid        = 1'b0;
    dma_read_ctrl_data_index   = '0;
    dma_read_ctrl_data_length  = '0;
    dma_write_ctrl_valid       = 1'b0;
    dma_write_ctrl_data_index  = '0;
    dma_write_ctrl_data_length = '0;
    dma_read_chnl_ready        = 1'b0;
    cmp_in_valid               = 1'b0;
    dma_write_chnl_valid       = 1'b0;
    cmp_out_ready              = 1'b0;
    acc_done                   = 1'b0;
    case (state_q)
      S_RD_REQ: begin
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = src_q + offset_q;
        dma_read_ctrl_data_length = DW'(cur_len);
      end
      S_RD_DATA: begin
        cmp_in_valid        = dma_read_chnl_valid;
        dma_read_chnl_ready = cmp_in_ready;
      end
      S_WR_REQ: begin
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = dst_q + offset_q;
        dma_write_ctrl_data_length = DW'(cur_len);
      end
      S_WR_DATA: begin
        dma_write_chnl_valid = cmp_out_valid;
        cmp_out_ready        = dma_write_chnl_ready;
      end
      S_DONE:  acc_done = 1'b1;
      default: ;
    endcase
  end

  // Transfer bookkeeping: latched config, progress and per-chunk beat count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      offset_q    <= '0;
      chunk_q     <= '0;
      beat_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (conf_done) begin
          src_q       <= conf_info_src_offset;
          dst_q       <= conf_info_dst_offset;
          remaining_q <= conf_info_num_words;
          chunk_q     <= (conf_info_chunk_words == '0) ? LW'(1) : conf_info_chunk_words;
          offset_q    <= '0;
          beat_q      <= '0;
        end
        S_RD_REQ:  if (dma_read_ctrl_ready) beat_q <= cur_len;
        S_RD_DATA: if (rd_fire) beat_q <= beat_q - LW'(1);
        S_WR_REQ:  if (dma_write_ctrl_ready) beat_q <= cur_len;
        S_WR_DATA: if (wr_fire) begin
          beat_q <= beat_q - LW'(1);
          if (last_beat) begin
            offset_q    <= offset_q + DW'(cur_len);
            remaining_q <= remaining_q - DW'(cur_len);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HU_AUDIODEC_SEQ_DEBUG_EN
  logic [11:0] chunk_cnt_q;

  // Completed-chunk counter, cleared at each new transfer; wraps at 4096.
  always_ff @(posedge clk) begin
    if (!rst)                                chunk_cnt_q <= '0;
    else if (state_q == S_IDLE && conf_done) chunk_cnt_q <= '0;
    else if (wr_fire && last_beat)           chunk_cnt_q <= chunk_cnt_q + 12'(1);
  end

  assign debug = {4'(state_q), chunk_cnt_q, beat_q};
`else
  assign debug = '0;
`endif

endmodule
